// File: rtl/cache_mem_system.sv
// -----------------------------------------------------------------------------
// cache_mem_system
//   Direct-mapped, write-back, write-allocate data cache in front of a 1 KiB
//   word-organised main memory. One CPU access (read or write) is performed on
//   every non-reset rising clock edge. A miss is serviced in the same edge:
//   a dirty victim is written back, the line is filled from memory, and the
//   access completes on the freshly filled line, so the block never stalls.
//
// Ports
//   clk        in   1       system clock, rising-edge active
//   reset      in   1       synchronous active-high reset
//   readWrite  in   1       0 = read, 1 = write
//   addr       in   ADDR_W  byte address (bits [1:0] ignored)
//   writeData  in   DATA_W  store data for writes
//   hitMiss    out  1       1 = last access hit, 0 = missed (registered)
//   readData   out  DATA_W  word returned by the last read (registered)
//
// Address split (default parameters): tag=[9:6] index=[5:4] word=[3:2]
// -----------------------------------------------------------------------------
module cache_mem_system #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int NUM_BLOCKS  = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic              hitMiss,
  output logic [DATA_W-1:0] readData
);

  localparam int IDX_W     = $clog2(NUM_BLOCKS);
  localparam int OFF_W     = $clog2(BLOCK_WORDS);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W - 2;
  localparam int MEM_AW    = ADDR_W - 2;
  localparam int MEM_WORDS = 1 << MEM_AW;

  // Cache state: control bits per line plus the tag and data arrays.
  logic [NUM_BLOCKS-1:0] validBits;
  logic [NUM_BLOCKS-1:0] dirtyBits;
  logic [TAG_W-1:0]      tagArr  [NUM_BLOCKS];
  logic [DATA_W-1:0]     dataArr [NUM_BLOCKS][BLOCK_WORDS];

  // Backing store, word addressed.
  logic [DATA_W-1:0]     mem [MEM_WORDS];

  // Request decode.
  logic [TAG_W-1:0]      reqTag;
  logic [IDX_W-1:0]      reqIndex;
  logic [OFF_W-1:0]      reqWord;
  logic [TAG_W-1:0]      victimTag;
  logic                  hit;
  logic                  writeBack;

  // Line contents after the (possible) fill, and after applying a write.
  logic [DATA_W-1:0]     filledLine  [BLOCK_WORDS];
  logic [DATA_W-1:0]     updatedLine [BLOCK_WORDS];

  // Byte offset within a word is ignored.
  logic                  unusedByteBits;
  assign unusedByteBits = ^addr[1:0];

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    reqTag    = addr[ADDR_W-1 -: TAG_W];
    reqIndex  = addr[OFF_W+2 +: IDX_W];
    reqWord   = addr[2 +: OFF_W];
    victimTag = tagArr[reqIndex];
    hit       = validBits[reqIndex] && (victimTag == reqTag);
    // Only a valid, dirty victim has to go back to memory; a clean line
    // already matches memory and is simply overwritten.
    writeBack = !hit && validBits[reqIndex] && dirtyBits[reqIndex];

    for (int w = 0; w < BLOCK_WORDS; w++) begin
      // On a miss the victim tag differs from the request tag (or the line is
      // invalid), so the fill never reads words that the write-back touches.
      filledLine[w] = hit ? dataArr[reqIndex][w]
                          : mem[{reqTag, reqIndex, OFF_W'(w)}];
    end

    updatedLine = filledLine;
    if (readWrite) begin
      updatedLine[reqWord] = writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only the valid/dirty bits need clearing to empty the cache; the
      // tag and data arrays are don't-care while invalid and stay unreset.
      // Main memory, however, has a defined power-on image (word i holds i),
      // so it is rewritten here, which also discards any unflushed dirty data.
      validBits <= '0;
      dirtyBits <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= DATA_W'(i);
      end
      hitMiss  <= 1'b0;
      readData <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments so every read
      // above sees the pre-edge contents, whatever the statement order.
      if (writeBack) begin
        for (int w = 0; w < BLOCK_WORDS; w++) begin
          mem[{victimTag, reqIndex, OFF_W'(w)}] <= dataArr[reqIndex][w];
        end
      end

      for (int w = 0; w < BLOCK_WORDS; w++) begin
        dataArr[reqIndex][w] <= updatedLine[w];
      end
      tagArr[reqIndex]    <= reqTag;
      validBits[reqIndex] <= 1'b1;
      // A write always dirties the line; a read keeps the dirty bit on a hit
      // and leaves a freshly filled line clean.
      dirtyBits[reqIndex] <= readWrite | (hit & dirtyBits[reqIndex]);

      hitMiss <= hit;
      if (!readWrite) begin
        readData <= filledLine[reqWord];
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_system.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_system
//   Scenario tasks push the expected (hitMiss, readData) of each access into a
//   scoreboard queue as the access is driven; a monitor pops and compares once
//   the DUT outputs have settled after the clock edge.
// -----------------------------------------------------------------------------
module tb_cache_mem_system;

  logic        clk = 1'b0;
  logic        reset;
  logic        readWrite;
  logic [9:0]  addr;
  logic [31:0] writeData;
  logic        hitMiss;
  logic [31:0] readData;

  always #5 clk = ~clk;

  cache_mem_system dut (
    .clk       (clk),
    .reset     (reset),
    .readWrite (readWrite),
    .addr      (addr),
    .writeData (writeData),
    .hitMiss   (hitMiss),
    .readData  (readData)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] lastRd     = 32'd0;
  event        sampled;

  // Reference model for the random phase: a flat memory (the cache must be
  // transparent) plus a tag directory to predict hit/miss.
  logic [31:0] refMem   [256];
  logic [3:0]  refTag   [4];
  logic        refValid [4];

  // Scoreboard monitor: one expectation per completed access.
  always @(sampled) begin
    exp_t e;
    checkCount++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: DUT access with no queued expectation");
    end else begin
      e = sb.pop_front();
      if (hitMiss !== e.hit || readData !== e.data)
        $display("FAIL %s: got hitMiss=%0b readData=0x%0h, expected hitMiss=%0b readData=0x%0h",
                 e.name, hitMiss, readData, e.hit, e.data);
      else
        passCount++;
    end
  end

  task automatic push_exp(input string n, input logic rw, input logic h,
                          input logic [31:0] d);
    // Writes leave readData at the value of the previous read.
    if (!rw) lastRd = d;
    sb.push_back('{n, h, lastRd});
  endtask

  task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    reset     = 1'b0;
    readWrite = rw;
    addr      = a;
    writeData = d;
    @(posedge clk);
    #1;
    -> sampled;
  endtask

  task automatic exp_access(input string n, input logic rw, input logic [9:0] a,
                            input logic [31:0] d, input logic h, input logic [31:0] rd);
    push_exp(n, rw, h, rd);
    access(rw, a, d);
  endtask

  // Reset cycle; a write is presented during it and must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    readWrite = 1'b1;
    addr      = 10'd0;
    writeData = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    lastRd = 32'd0;
    for (int i = 0; i < 256; i++) refMem[i] = 32'(i);
    for (int i = 0; i < 4; i++) refValid[i] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checkCount++;
    if (hitMiss !== 1'b0 || readData !== 32'd0)
      $display("FAIL reset_outputs: got hitMiss=%0b readData=0x%0h, expected 0/0x0",
               hitMiss, readData);
    else
      passCount++;
  endtask

  task automatic test_fill();
    exp_access("read0_miss", 1'b0, 10'd0, 32'd0, 1'b0, 32'd0);
    exp_access("read4_hit",  1'b0, 10'd4, 32'd0, 1'b1, 32'd1);
  endtask

  task automatic test_write_hit();
    exp_access("write8_hit", 1'b1, 10'd8, 32'hAA, 1'b1, 32'd0);
    exp_access("read8_hit",  1'b0, 10'd8, 32'd0,  1'b1, 32'hAA);
  endtask

  task automatic test_evict();
    exp_access("read256_evict_dirty", 1'b0, 10'd256, 32'd0, 1'b0, 32'd64);
    exp_access("read8_after_wb",      1'b0, 10'd8,   32'd0, 1'b0, 32'hAA);
    exp_access("read260_evict_clean", 1'b0, 10'd260, 32'd0, 1'b0, 32'd65);
    exp_access("read8_again",         1'b0, 10'd8,   32'd0, 1'b0, 32'hAA);
    exp_access("read12_same_line",    1'b0, 10'd12,  32'd0, 1'b1, 32'd3);
  endtask

  task automatic test_write_miss();
    exp_access("write1020_miss", 1'b1, 10'd1020, 32'd7, 1'b0, 32'd0);
    exp_access("read1020_hit",   1'b0, 10'd1020, 32'd0, 1'b1, 32'd7);
    exp_access("read1016_hit",   1'b0, 10'd1016, 32'd0, 1'b1, 32'd254);
  endtask

  task automatic test_byte_offset();
    do_reset();
    exp_access("read6_miss", 1'b0, 10'd6, 32'd0, 1'b0, 32'd1);
    exp_access("read7_hit",  1'b0, 10'd7, 32'd0, 1'b1, 32'd1);
    exp_access("read9_hit",  1'b0, 10'd9, 32'd0, 1'b1, 32'd2);
  endtask

  task automatic test_reset_discard();
    exp_access("write12_dirty", 1'b1, 10'd12, 32'h55, 1'b1, 32'd0);
    exp_access("read12_dirty",  1'b0, 10'd12, 32'd0,  1'b1, 32'h55);
    do_reset();
    exp_access("read12_post_reset", 1'b0, 10'd12,  32'd0, 1'b0, 32'd3);
    exp_access("read268_evict",     1'b0, 10'd268, 32'd0, 1'b0, 32'd67);
    exp_access("read12_from_mem",   1'b0, 10'd12,  32'd0, 1'b0, 32'd3);
  endtask

  // Back-to-back random traffic over a few tags so lines are evicted often.
  task automatic test_back_to_back();
    logic [3:0]  tagSel [4];
    logic [9:0]  a;
    logic [3:0]  t;
    logic [1:0]  idx;
    logic        rw;
    logic [31:0] d;
    logic        h;
    tagSel = '{4'd0, 4'd1, 4'd9, 4'd15};
    do_reset();
    for (int n = 0; n < 300; n++) begin
      t   = tagSel[$urandom_range(0, 3)];
      idx = 2'($urandom_range(0, 3));
      a   = {t, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rw  = 1'($urandom_range(0, 1));
      d   = $urandom;
      h   = refValid[idx] && (refTag[idx] == t);
      refValid[idx] = 1'b1;
      refTag[idx]   = t;
      push_exp($sformatf("rand%0d_%s_0x%0h", n, rw ? "wr" : "rd", a), rw, h, refMem[a[9:2]]);
      if (rw) refMem[a[9:2]] = d;
      access(rw, a, d);
    end
  endtask

  initial begin
    reset     = 1'b1;
    readWrite = 1'b0;
    addr      = 10'd0;
    writeData = 32'd0;
    test_reset();
    test_fill();
    test_write_hit();
    test_evict();
    test_write_miss();
    test_byte_offset();
    test_reset_discard();
    test_back_to_back();
    #1;
    checkCount++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    else
      passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
